// File: rtl/keeper_pos_receiver.sv
// rtl/keeper_pos_receiver.sv - keeper-position link decoder: pops tagged LO/HI bytes from the RX FIFO
// and rebuilds the 10-bit keeper x-position, resyncing on bad, lost or late bytes.
module keeper_pos_receiver #(
  parameter logic [9:0]  RESET_XPOS = 10'd512,
  parameter logic [9:0]  X_MAX      = 10'd1023,
  parameter int unsigned TIMEOUT    = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_rd,
  input  logic       en,
  output logic [9:0] keeper_xpos,
  output logic       pos_valid,
  output logic [7:0] err_cnt
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [2:0] TAG_LO = 3'b001;
  localparam logic [2:0] TAG_HI = 3'b010;

  typedef enum logic [1:0] {WAIT_LO, POP_LO, WAIT_HI, POP_HI} state_t;

  state_t          state_q, state_d;
  logic [4:0]      lo_buf_q, lo_buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      xpos_q, xpos_d;
  logic            rx_rd_q, rx_rd_d;
  logic            pos_valid_q, pos_valid_d;
  logic [7:0]      err_q, err_d;
  logic            err_inc;

  logic [2:0] tag;
  logic [4:0] payload;
  logic [9:0] x_full;

  assign tag     = rx_data[2:0];
  assign payload = rx_data[7:3];
  assign x_full  = {payload, lo_buf_q};

  always_comb begin
    state_d     = state_q;
    lo_buf_d    = lo_buf_q;
    cnt_d       = cnt_q;
    xpos_d      = xpos_q;
    pos_valid_d = 1'b0;
    err_inc     = 1'b0;
    case (state_q)
      WAIT_LO: begin
        if (!rx_empty) begin
          if (tag == TAG_LO) begin
            lo_buf_d = payload;
            state_d  = POP_LO;
          end else begin
            err_inc = 1'b1;
            state_d = POP_HI;
          end
        end
      end
      POP_LO: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        // A byte arriving on the timeout cycle takes priority over the timeout.
        if (!rx_empty) begin
          if (tag == TAG_HI) begin
            if (en) begin
              xpos_d      = (x_full > X_MAX) ? X_MAX : x_full;
              pos_valid_d = 1'b1;
            end
            state_d = POP_HI;
          end else if (tag == TAG_LO) begin
            lo_buf_d = payload;
            err_inc  = 1'b1;
            state_d  = POP_LO;
          end else begin
            err_inc = 1'b1;
            state_d = POP_HI;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_inc = 1'b1;
          state_d = WAIT_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      POP_HI:  state_d = WAIT_LO;
      default: state_d = WAIT_LO;
    endcase
    rx_rd_d = (state_d == POP_LO) || (state_d == POP_HI);
    err_d   = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LO;
      lo_buf_q    <= '0;
      cnt_q       <= '0;
      xpos_q      <= RESET_XPOS;
      rx_rd_q     <= 1'b0;
      pos_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      lo_buf_q    <= lo_buf_d;
      cnt_q       <= cnt_d;
      xpos_q      <= xpos_d;
      rx_rd_q     <= rx_rd_d;
      pos_valid_q <= pos_valid_d;
      err_q       <= err_d;
    end
  end

  assign rx_rd       = rx_rd_q;
  assign keeper_xpos = xpos_q;
  assign pos_valid   = pos_valid_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_keeper_pos_receiver.sv
// tb/tb_keeper_pos_receiver.sv - scoreboard bench for keeper_pos_receiver with a FWFT FIFO model.
module tb_keeper_pos_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rd;
  logic       en = 1'b1;
  logic [9:0] keeper_xpos;
  logic       pos_valid;
  logic [7:0] err_cnt;

  keeper_pos_receiver #(
    .RESET_XPOS(10'd512),
    .X_MAX     (10'd1000),
    .TIMEOUT   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_empty   (rx_empty),
    .rx_data    (rx_data),
    .rx_rd      (rx_rd),
    .en         (en),
    .keeper_xpos(keeper_xpos),
    .pos_valid  (pos_valid),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo[$];
  int         exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         rd_cnt   = 0;
  int         exp_err  = 0;
  logic       pv_prev  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // FIFO model: pop on the registered strobe, head refreshed mid-cycle.
  always @(negedge clk) begin
    if (rx_rd && fifo.size() > 0) void'(fifo.pop_front());
    rx_empty = (fifo.size() == 0);
    rx_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  // Monitor: pops the scoreboard whenever a position is presented.
  always @(negedge clk) begin
    if (rx_rd) rd_cnt++;
    if (pos_valid) begin
      check("pos_valid_not_back_to_back", int'(pv_prev), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pos_valid", 1, 0);
      end else begin
        check("keeper_xpos_on_pulse", int'(keeper_xpos), exp_q.pop_front());
      end
    end
    pv_prev = pos_valid;
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int rd_base;

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_xpos", int'(keeper_xpos), 512);
    check("reset_rx_rd", int'(rx_rd), 0);
    check("reset_pos_valid", int'(pos_valid), 0);
    check("reset_err_cnt", int'(err_cnt), 0);
    settle(3);
    rst_n = 1'b1;
    settle(2);

    rd_base = rd_cnt;
    exp_q.push_back(501);
    push(8'hA9); push(8'h7A);
    settle(10);
    check("pair_rd_pulses", rd_cnt - rd_base, 2);
    check("pair_xpos", int'(keeper_xpos), 501);
    check("pair_err", int'(err_cnt), exp_err);

    rd_base = rd_cnt;
    push(8'h7A);
    exp_err++;
    settle(8);
    check("orphan_hi_rd", rd_cnt - rd_base, 1);
    check("orphan_hi_err", int'(err_cnt), exp_err);
    check("orphan_hi_xpos", int'(keeper_xpos), 501);

    exp_q.push_back(997);
    push(8'h09); push(8'h29); push(8'hFA);
    exp_err++;
    settle(12);
    check("double_lo_err", int'(err_cnt), exp_err);
    check("double_lo_xpos", int'(keeper_xpos), 997);

    exp_q.push_back(1000);
    push(8'hF9); push(8'hFA);
    settle(10);
    check("clamp_xpos", int'(keeper_xpos), 1000);
    check("clamp_err", int'(err_cnt), exp_err);

    push(8'h09);
    exp_err++;
    settle(30);
    check("timeout_err", int'(err_cnt), exp_err);
    push(8'h7A);
    exp_err++;
    settle(8);
    check("after_timeout_err", int'(err_cnt), exp_err);
    check("after_timeout_xpos", int'(keeper_xpos), 1000);

    en = 1'b0;
    rd_base = rd_cnt;
    push(8'hA9); push(8'h7A);
    settle(10);
    en = 1'b1;
    check("en0_rd_pulses", rd_cnt - rd_base, 2);
    check("en0_xpos_held", int'(keeper_xpos), 1000);
    check("en0_err", int'(err_cnt), exp_err);

    push(8'hA9);
    settle(6);
    #2 rst_n = 1'b0;
    #1;
    exp_err = 0;
    check("midpair_reset_xpos", int'(keeper_xpos), 512);
    check("midpair_reset_err", int'(err_cnt), 0);
    check("midpair_reset_rx_rd", int'(rx_rd), 0);
    rd_base = rd_cnt;
    settle(4);
    check("no_pop_in_reset", rd_cnt - rd_base, 0);
    rst_n = 1'b1;
    settle(2);
    push(8'h7A);
    exp_err++;
    settle(8);
    check("post_reset_hi_err", int'(err_cnt), exp_err);
    check("post_reset_hi_xpos", int'(keeper_xpos), 512);

    for (int i = 0; i < 300; i++) push(8'h00);
    settle(700);
    check("err_saturate", int'(err_cnt), 255);
    check("fifo_drained", fifo.size(), 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
